// File: rtl/lut_dump_capture_buf_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : lut_dump_pkg                                                 |
// | Description : Shared FSM state type and capture-length clamp helper.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package lut_dump_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

  // A zero or oversized request means "fill the whole buffer".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_dump_capture_buf_if.sv
// +----------------------------------------------------------------------------+
// | Interface   : lut_dump_capture_buf_if                                      |
// | Description : Sample input, capture control/status and CPU read bus.      |
// |               DUMP_DECIM_EN adds the decim control.                        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lut_dump_capture_buf_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CPU_W  = 32,
  parameter int ADDR_W = 10
);
  logic [LANES*DATA_W-1:0] din;
  logic                    din_valid;
  logic                    arm;
  logic                    trigger;
  logic [ADDR_W:0]         cap_len;
  logic                    busy;
  logic                    done;
  logic [ADDR_W:0]         wr_count;
  logic                    cpu_rd_en;
  logic [ADDR_W-1:0]       cpu_rd_addr;
  logic [CPU_W-1:0]        cpu_rd_data;
  logic                    cpu_rd_valid;
`ifdef DUMP_DECIM_EN
  logic [7:0]              decim;
`endif

  modport master (
`ifdef DUMP_DECIM_EN
    output decim,
`endif
    output din, din_valid, arm, trigger, cap_len, cpu_rd_en, cpu_rd_addr,
    input  busy, done, wr_count, cpu_rd_data, cpu_rd_valid
  );

  modport slave (
`ifdef DUMP_DECIM_EN
    input  decim,
`endif
    input  din, din_valid, arm, trigger, cap_len, cpu_rd_en, cpu_rd_addr,
    output busy, done, wr_count, cpu_rd_data, cpu_rd_valid
  );

endinterface

`default_nettype wire

// File: rtl/lut_dump_capture_buf_ram.sv
// +----------------------------------------------------------------------------+
// | Module      : lut_dump_sdp_ram                                             |
// | Description : Simple dual-port inferred BRAM, read-first, registered out.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module lut_dump_sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lut_dump_capture_buf.sv
// +----------------------------------------------------------------------------+
// | Module      : lut_dump_capture_buf                                         |
// | Description : Armed/triggered LUT sample capture into BRAM with CPU read.  |
// |               Optional macro DUMP_DECIM_EN enables beat decimation.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module lut_dump_capture_buf
  import lut_dump_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CPU_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  lut_dump_capture_buf_if.slave bus
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_W;

  if (LANES * DATA_W != CPU_W) begin : g_width_err
    $error("LANES*DATA_W must equal CPU_W");
  end

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_capturing;
  logic              w_keep;
  logic              w_accept;
  logic [CPU_W-1:0]  w_ram_rdata;
  logic              rd_pipe_q;
  logic              rd_valid_q;
  logic [CPU_W-1:0]  rd_data_q;

  // The trigger cycle itself is a capture cycle so a coincident beat lands.
  assign w_capturing = ((state_q == S_ARMED) && bus.trigger) || (state_q == S_CAPTURE);

`ifdef DUMP_DECIM_EN
  logic [7:0] dec_cnt_q, dec_cnt_d, w_cnt_eff;

  always_comb begin
    w_cnt_eff = (state_q == S_ARMED) ? 8'd0 : dec_cnt_q;
    w_keep    = bus.din_valid && (w_cnt_eff == 8'd0);
    dec_cnt_d = (state_q == S_ARMED) ? 8'd0 : dec_cnt_q;
    if (w_capturing && bus.din_valid) begin
      dec_cnt_d = (w_cnt_eff == bus.decim) ? 8'd0 : 8'(w_cnt_eff + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q <= 8'd0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end
`else
  assign w_keep = bus.din_valid;
`endif

  assign w_accept    = w_capturing && w_keep;
  assign w_count_inc = wr_count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.arm) begin
          state_d    = S_ARMED;
          len_d      = (ADDR_W+1)'(clamp_len(32'(bus.cap_len), RAM_DEPTH));
          wr_count_d = '0;
        end
      end
      S_ARMED: begin
        if (bus.trigger) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: ;
      default: state_d = S_IDLE;
    endcase
    if (w_accept) begin
      wr_count_d = w_count_inc;
      if (w_count_inc == len_q) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
    end
  end

  lut_dump_sdp_ram #(
    .DW (CPU_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_accept),
    .waddr_i (wr_count_q[ADDR_W-1:0]),
    .wdata_i (bus.din),
    .re_i    (bus.cpu_rd_en),
    .raddr_i (bus.cpu_rd_addr),
    .rdata_o (w_ram_rdata)
  );

  // Second output register; data only advances with a live read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pipe_q  <= bus.cpu_rd_en;
      rd_valid_q <= rd_pipe_q;
      if (rd_pipe_q) begin
        rd_data_q <= w_ram_rdata;
      end
    end
  end

  assign bus.busy         = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.wr_count     = wr_count_q;
  assign bus.cpu_rd_data  = rd_data_q;
  assign bus.cpu_rd_valid = rd_valid_q;

endmodule

`default_nettype wire
